// File: rtl/sixbitpow_seq.sv
// rtl/sixbitpow_seq.sv - sequential ain^bin controller, one multiply per clock
//
// Computes ain^bin mod 2^WIDTH by repeated multiplication. It also keeps a
// sticky flag for any product bits lost to truncation.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     request an operation; sampled only in IDLE
//   ain, bin  base and exponent, captured when start is accepted
//   pow       registered result, updated on entry to DONE
//   overflow  registered flag, set when the true power exceeds 2^WIDTH-1
//   busy      high in RUN and DONE
//   done      one-cycle pulse while in DONE
module sixbitpow_seq #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] pow,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] cnt;
   logic             ovf_q;
   logic             cnt_zero;
   logic [2*WIDTH-1:0] prod;

   assign cnt_zero = (cnt == '0);

   // The full-width product exposes the bits dropped by truncation. Those
   // bits feed the sticky overflow flag. The low half is exact mod 2^WIDTH.
   assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, a_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_zero) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         acc      <= ONE;
         cnt      <= '0;
         ovf_q    <= 1'b0;
         pow      <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= ain;
                  cnt   <= bin;
                  acc   <= ONE;
                  ovf_q <= 1'b0;
               end
            end
            RUN: begin
               if (!cnt_zero) begin
                  acc   <= prod[WIDTH-1:0];
                  ovf_q <= ovf_q | (prod[2*WIDTH-1:WIDTH] != '0);
                  cnt   <= cnt - ONE;
               end else begin
                  // pow and overflow change only here, so they hold the
                  // previous result for the whole of RUN.
                  pow      <= acc;
                  overflow <= ovf_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
